// File: rtl/step_sequencer_pkg.sv
// Shared types and constants for the 4-track x 16-step drum pattern sequencer.
package step_sequencer_pkg;

    localparam int unsigned NUM_TRACKS = 4;
    localparam int unsigned NUM_STEPS  = 16;
    localparam int unsigned STEP_W     = $clog2(NUM_STEPS);
    localparam int unsigned TRK_W      = 2;
    localparam int unsigned TEMPO_W    = 8;

    typedef enum logic [TRK_W-1:0] {
        TRK_KICK  = 2'd0,
        TRK_SNARE = 2'd1,
        TRK_HAT   = 2'd2,
        TRK_CLAP  = 2'd3
    } track_e;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [NUM_TRACKS-1:0] trk_mask_t;

    // Step-major storage so one step's column is a single slice.
    typedef logic [NUM_STEPS-1:0][NUM_TRACKS-1:0] pattern_t;

    // Lowest active track index wins (kick > snare > hat > clap).
    function automatic logic [TRK_W-1:0] prio_sel(input trk_mask_t m);
        prio_sel = TRK_W'(TRK_KICK);
        for (int i = int'(NUM_TRACKS) - 1; i >= 0; i--) begin
            if (m[i[TRK_W-1:0]]) prio_sel = i[TRK_W-1:0];
        end
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control, pattern-write and trigger signals between the UI/host and the sequencer.
interface step_sequencer_if;
    import step_sequencer_pkg::*;

    logic               start;
    logic               stop;
    logic [TEMPO_W-1:0] tempo;
    logic               wr_en;
    logic [TRK_W-1:0]   wr_track;
    logic [STEP_W-1:0]  wr_step;
    logic               wr_val;
    logic               clr;
    logic               go;
    logic [TRK_W-1:0]   sel;
    trk_mask_t          hits;
    logic [STEP_W-1:0]  step;
    logic               running;

    modport master (
        output start, stop, tempo, wr_en, wr_track, wr_step, wr_val, clr,
        input  go, sel, hits, step, running
    );

    modport slave (
        input  start, stop, tempo, wr_en, wr_track, wr_step, wr_val, clr,
        output go, sel, hits, step, running
    );

endinterface

// File: rtl/step_sequencer_tempo_timer.sv
// Tempo prescaler plus period counter; step_tick pulses once every (tempo+1) ticks.
module step_sequencer_tempo_timer
    import step_sequencer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic [TEMPO_W-1:0] tempo,
    output logic               step_tick
);

    localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PRE_W-1:0]   pre_q;
    logic [TEMPO_W-1:0] per_q;
    logic               tick;

    assign tick = (pre_q == PRE_W'(TICK_CYCLES - 1));
    // >= so that lowering tempo below the current count fires at once rather than skipping.
    assign step_tick = tick && (per_q >= tempo);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
            per_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
            per_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            per_q <= step_tick ? '0 : per_q + TEMPO_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern sequencer top: run/stop FSM, pattern store, step counter and trigger outputs.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            resetn,
    step_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    pattern_t          pattern_q;
    logic [STEP_W-1:0] step_q, step_d;
    trk_mask_t         hits_q, hits_d, col;
    logic [TRK_W-1:0]  sel_q, sel_d;
    logic              go_q, go_d;
    logic              running_q, running_d;
    logic              fire, clear, step_tick;

    step_sequencer_tempo_timer #(.TICK_CYCLES(TICK_CYCLES)) u_tempo_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .tempo     (bus.tempo),
        .step_tick (step_tick)
    );

    // Next state, next step and the column fired on this edge.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        go_d    = 1'b0;
        hits_d  = '0;
        sel_d   = sel_q;
        fire    = 1'b0;
        clear   = 1'b0;
        col     = '0;
        unique case (state_q)
            ST_STOP: begin
                clear  = 1'b1;
                step_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                    fire    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_STOP;
                    step_d  = '0;
                    clear   = 1'b1;
                end else if (bus.start) begin
                    step_d = '0;
                    fire   = 1'b1;
                    clear  = 1'b1;
                end else if (step_tick) begin
                    step_d = (step_q == STEP_W'(NUM_STEPS - 1)) ? '0 : step_q + STEP_W'(1);
                    fire   = 1'b1;
                end
            end
            default: begin
                state_d = ST_STOP;
                step_d  = '0;
                clear   = 1'b1;
            end
        endcase
        // pattern_q is the pre-write value, so a same-edge write only affects later visits.
        if (fire) begin
            col    = pattern_q[step_d];
            hits_d = col;
            go_d   = |col;
            if (|col) sel_d = prio_sel(col);
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_STOP;
            step_q    <= '0;
            go_q      <= 1'b0;
            hits_q    <= '0;
            sel_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            go_q      <= go_d;
            hits_q    <= hits_d;
            sel_q     <= sel_d;
            running_q <= running_d;
        end
    end

    // Pattern store; clear beats a write in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pattern_q <= '0;
        end else if (bus.clr) begin
            pattern_q <= '0;
        end else if (bus.wr_en) begin
            pattern_q[bus.wr_step][bus.wr_track] <= bus.wr_val;
        end
    end

    assign bus.go      = go_q;
    assign bus.sel     = sel_q;
    assign bus.hits    = hits_q;
    assign bus.step    = step_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: vector table, directed timing sequences and random traffic vs a model.
module tb_step_sequencer;
    import step_sequencer_pkg::*;

    localparam int TICK = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    step_sequencer_if bus();

    step_sequencer #(.TICK_CYCLES(TICK)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;

    // Reference model: elapsed cycles since the last fired step decide the next boundary.
    logic [3:0] m_pat [16];
    bit         m_run;
    int         m_step;
    int         m_age;
    int         m_sel;
    bit         m_go;
    int         m_hits;

    function automatic void model_reset();
        m_run = 0; m_step = 0; m_age = 0; m_sel = 0; m_go = 0; m_hits = 0;
        foreach (m_pat[i]) m_pat[i] = 4'b0000;
    endfunction

    function automatic void model_edge();
        bit fire = 0;
        logic [3:0] c;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_go = 0;
        m_hits = 0;
        if (bus.stop) begin
            m_run = 0; m_step = 0;
        end else if (bus.start) begin
            m_run = 1; m_step = 0; m_age = 0; fire = 1;
        end else if (m_run) begin
            m_age++;
            if ((m_age % TICK) == 0 && (m_age / TICK) >= int'(bus.tempo) + 1) begin
                m_step = (m_step + 1) % 16;
                m_age = 0;
                fire = 1;
            end
        end
        if (fire) begin
            c = m_pat[m_step];
            m_hits = int'(c);
            m_go = (c != 4'b0000);
            for (int t = 3; t >= 0; t--) if (c[t]) m_sel = t;
        end
        if (bus.clr) foreach (m_pat[i]) m_pat[i] = 4'b0000;
        else if (bus.wr_en) m_pat[bus.wr_step][bus.wr_track] = bus.wr_val;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model follows the same inputs, outputs compared 1ns after the edge.
    task automatic tick1();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_go", int'(bus.go), int'(m_go));
        chk("model_sel", int'(bus.sel), m_sel);
        chk("model_hits", int'(bus.hits), m_hits);
        chk("model_step", int'(bus.step), m_step);
        chk("model_running", int'(bus.running), int'(m_run));
        bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0; bus.clr = 1'b0;
    endtask

    task automatic write(input int trk, input int stp, input bit val);
        bus.wr_en = 1'b1;
        bus.wr_track = 2'(trk);
        bus.wr_step = 4'(stp);
        bus.wr_val = val;
        tick1();
    endtask

    task automatic wait_go(input int budget, output int n);
        n = 0;
        do begin
            tick1();
            n++;
        end while (!bus.go && n < budget);
        if (!bus.go) chk("wait_go_timeout", 0, 1);
    endtask

    typedef struct {
        bit start;
        bit stop;
        int wait_n;
        int go;
        int sel;
        int hits;
        int step;
        int running;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int n, t, cnt, gstep, nbad, last_step;

        bus.start = 0; bus.stop = 0; bus.tempo = 8'd1; bus.wr_en = 0;
        bus.wr_track = 0; bus.wr_step = 0; bus.wr_val = 0; bus.clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_go", int'(bus.go), 0);
        chk("rst_hits", int'(bus.hits), 0);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_sel", int'(bus.sel), 0);
        resetn = 1'b1;

        // Pattern: kick@0, snare@4, hat on every step.
        write(0, 0, 1);
        write(1, 4, 1);
        for (int s = 0; s < 16; s++) write(2, s, 1);

        tbl[0] = '{1, 0, 1,  1, 0, 4'b0101, 0, 1};
        tbl[1] = '{0, 0, 7,  0, 0, 0,       0, 1};
        tbl[2] = '{0, 0, 1,  1, 2, 4'b0100, 1, 1};
        tbl[3] = '{0, 0, 24, 1, 1, 4'b0110, 4, 1};
        tbl[4] = '{0, 0, 1,  0, 1, 0,       4, 1};
        tbl[5] = '{1, 1, 1,  0, 1, 0,       0, 0};
        tbl[6] = '{1, 0, 1,  1, 0, 4'b0101, 0, 1};
        for (int i = 0; i < 7; i++) begin
            bus.start = tbl[i].start;
            bus.stop = tbl[i].stop;
            repeat (tbl[i].wait_n) tick1();
            chk($sformatf("vec%0d_go", i), int'(bus.go), tbl[i].go);
            chk($sformatf("vec%0d_sel", i), int'(bus.sel), tbl[i].sel);
            chk($sformatf("vec%0d_hits", i), int'(bus.hits), tbl[i].hits);
            chk($sformatf("vec%0d_step", i), int'(bus.step), tbl[i].step);
            chk($sformatf("vec%0d_running", i), int'(bus.running), tbl[i].running);
        end

        // Spacing, one-cycle go width and 15 -> 0 wrap.
        last_step = int'(bus.step);
        for (int k = 0; k < 17; k++) begin
            wait_go(40, n);
            chk("go_gap", n, 8);
            chk("step_seq", int'(bus.step), (last_step + 1) % 16);
            last_step = int'(bus.step);
        end

        // Tempo 1 -> 3 shortly after a boundary: next step 16 cycles after it.
        tick1();
        tick1();
        bus.tempo = 8'd3;
        wait_go(60, n);
        chk("tempo_gap", n + 2, 16);
        bus.tempo = 8'd1;

        // Write kick into the step that fires on this very edge.
        t = (int'(bus.step) + 1) % 16;
        repeat (7) tick1();
        write(0, t, 1);
        chk("samewr_go", int'(bus.go), 1);
        chk("samewr_step", int'(bus.step), t);
        chk("samewr_hits_old", int'(bus.hits), 4'b0100);
        n = 0;
        do begin
            tick1();
            n++;
        end while (!(bus.go && int'(bus.step) == t) && n < 200);
        chk("samewr_next_bar_hits", int'(bus.hits), 4'b0101);
        chk("samewr_next_bar_sel", int'(bus.sel), 0);

        // Only clap@3: single go per bar, sel held at 3 afterwards.
        bus.clr = 1'b1;
        tick1();
        write(3, 3, 1);
        bus.stop = 1'b1;
        tick1();
        bus.start = 1'b1;
        tick1();
        chk("empty_start_go", int'(bus.go), 0);
        cnt = 0; gstep = -1; nbad = 0;
        for (int c = 0; c < 128; c++) begin
            tick1();
            if (bus.go) begin
                cnt++;
                gstep = int'(bus.step);
            end
            if (int'(bus.step) >= 4 && int'(bus.sel) != 3) nbad++;
        end
        chk("empty_go_count", cnt, 1);
        chk("empty_go_step", gstep, 3);
        chk("empty_sel_not_held", nbad, 0);

        // Async reset in mid-step clears outputs and the pattern.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_go", int'(bus.go), 0);
        chk("arst_sel", int'(bus.sel), 0);
        chk("arst_hits", int'(bus.hits), 0);
        chk("arst_step", int'(bus.step), 0);
        chk("arst_running", int'(bus.running), 0);
        model_reset();
        tick1();
        tick1();
        resetn = 1'b1;
        bus.start = 1'b1;
        tick1();
        cnt = 0;
        for (int c = 0; c < 128; c++) begin
            tick1();
            if (bus.go || bus.hits != 4'b0000) cnt++;
        end
        chk("post_reset_silent", cnt, 0);
        chk("post_reset_running", int'(bus.running), 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.start = ($urandom_range(39) == 0);
            bus.stop = ($urandom_range(59) == 0);
            bus.clr = ($urandom_range(199) == 0);
            bus.wr_en = ($urandom_range(3) == 0);
            bus.wr_track = 2'($urandom_range(3));
            bus.wr_step = 4'($urandom_range(15));
            bus.wr_val = 1'($urandom_range(1));
            if ($urandom_range(99) == 0) bus.tempo = 8'($urandom_range(3));
            tick1();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
